tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//   Registered 1-to-4 time-division demultiplexer: the receive end of the 4:1 mux path.
//   Accepts one serial word stream whose beats arrive in slot order 0,1,2,3.
//   Reassembles each 4-slot frame and presents all four channels in parallel with a one-cycle strobe.
//   Detects framing faults: mid-frame resync and stalled frames.
// PARAMETERS
//   WIDTH    8   data word width of din and each channel output
//   GAP_MAX  8   consecutive idle cycles allowed inside a frame before abort (>=1)
// PORTS
//   clk          input   1      single clock, all logic on rising edge
//   rst_n        input   1      synchronous reset, active-low
//   din          input   WIDTH  serial data word for the current slot
//   din_valid    input   1      din carries a beat this cycle
//   frame_start  input   1      with din_valid: this beat is slot 0 of a new frame
//   y0           output  WIDTH  channel 0 word of last complete frame
//   y1           output  WIDTH  channel 1 word of last complete frame
//   y2           output  WIDTH  channel 2 word of last complete frame
//   y3           output  WIDTH  channel 3 word of last complete frame
//   frame_valid  output  1      one-cycle pulse: y0..y3 just updated
//   sync_err     output  1      one-cycle pulse: partial frame discarded
//   slot         output  2      next slot index expected (s1,s0)
//   busy         output  1      high while a frame is partially collected
// BEHAVIOUR
//   - Reset: rst_n low at a rising edge -> state IDLE; slot=0; y0..y3=0; capture buffers=0;
//     frame_valid=0, sync_err=0, gap counter=0. Reset has priority over every other input, mid-frame included.
//   - frame_start with din_valid low is ignored in every state.
//   - FSM states: IDLE, COLLECT. busy = (state==COLLECT).
//   - IDLE:
//     - din_valid & frame_start -> buf0<=din; slot<=1; enter COLLECT.
//     - din_valid without frame_start -> beat dropped, no error.
//   - COLLECT, din_valid & !frame_start:
//     - slots 1..2: buf[slot]<=din; slot<=slot+1; gap counter cleared.
//     - slot 3: y0..y2<=buf0..buf2 and y3<=din, all on the same edge.
//       frame_valid=1 for that one following cycle. slot wraps to 0; enter IDLE.
//   - COLLECT, din_valid & frame_start (resync):
//     - sync_err pulses one cycle; y0..y3 unchanged.
//     - buf0<=din; slot<=1; stay COLLECT; gap counter cleared.
//   - COLLECT, din_valid low:
//     - Gap counter increments.
//     - On the edge where it reaches GAP_MAX: sync_err pulses one cycle; enter IDLE; slot<=0; y unchanged.
//   - Latency: slot-3 beat sampled at edge N -> y0..y3 and frame_valid visible after edge N.
//     Back-to-back frames: a frame_start beat at edge N+1 is accepted.
//   - y0..y3 hold their value until the next complete frame. frame_valid and sync_err are never high together.
//   - Width: slot is 2-bit and wraps modulo 4. Gap counter is sized for GAP_MAX and saturates.
// TESTING
//   1. rst_n=0 for 2 edges mid-frame -> y0..y3=0, slot=0, busy=0, no pulses.
//   2. Beats 0x11(fs),0x22,0x33,0x44 on consecutive cycles -> y0..y3=11,22,33,44; frame_valid high 1 cycle; busy=0.
//   3. Same frame with 2 idle cycles between beats -> identical y; one frame_valid; no sync_err.
//   4. Sequence 0xA1(fs),0xA2, then 0xB1(fs),0xB2,0xB3,0xB4:
//      sync_err pulses at the 0xB1 edge; y then = B1,B2,B3,B4.
//   5. 0x01(fs),0x02 then 8 idle cycles -> sync_err on the 8th idle edge; busy=0; y keeps previous frame.
//   6. In IDLE, din_valid=1 with fs=0, din=0x55 -> no state change.
//      Back-to-back frames with fs each 4th beat -> frame_valid every 4 cycles.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive side of a 4:1 TDM link: reassembles 4-slot frames into parallel
// channel words and flags mid-frame resyncs and stalled frames.
module tdm_demux4 #(
    parameter int WIDTH   = 8,
    parameter int GAP_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic [1:0]       slot,
    output logic             busy
);

    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
    logic [WIDTH-1:0] cap0_q, cap0_d;
    logic [WIDTH-1:0] cap1_q, cap1_d;
    logic [WIDTH-1:0] cap2_q, cap2_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic [WIDTH-1:0] y3_q, y3_d;
    logic             fv_q, fv_d;
    logic             se_q, se_d;

    // Saturating idle-cycle count; the abort fires before saturation matters.
    assign gap_inc = (gap_q == GAP_LIM) ? gap_q : gap_q + 1'b1;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        gap_d   = gap_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        cap2_d  = cap2_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y3_d    = y3_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;

        case (state_q)
            IDLE: begin
                gap_d  = '0;
                slot_d = 2'd0;
                if (din_valid && frame_start) begin
                    cap0_d  = din;
                    slot_d  = 2'd1;
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (din_valid) begin
                    gap_d = '0;
                    if (frame_start) begin
                        // Resync: drop the partial frame, restart at slot 1.
                        se_d   = 1'b1;
                        cap0_d = din;
                        slot_d = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd1: begin
                                cap1_d = din;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                cap2_d = din;
                                slot_d = 2'd3;
                            end
                            2'd3: begin
                                y0_d    = cap0_q;
                                y1_d    = cap1_q;
                                y2_d    = cap2_q;
                                y3_d    = din;
                                fv_d    = 1'b1;
                                slot_d  = 2'd0;
                                state_d = IDLE;
                            end
                            default: begin
                                cap0_d = din;
                                slot_d = 2'd1;
                            end
                        endcase
                    end
                end else begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_LIM) begin
                        se_d    = 1'b1;
                        gap_d   = '0;
                        slot_d  = 2'd0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                slot_d  = 2'd0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= 2'd0;
            gap_q   <= '0;
            cap0_q  <= '0;
            cap1_q  <= '0;
            cap2_q  <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            gap_q   <= gap_d;
            cap0_q  <= cap0_d;
            cap1_q  <= cap1_d;
            cap2_q  <= cap2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign y3          = y3_q;
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
    assign slot        = slot_q;
    assign busy        = (state_q == COLLECT);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboarded random and directed bench for tdm_demux4 against a
// word-list frame model.
module tb_tdm_demux4;

    localparam int WIDTH   = 8;
    localparam int GAP_MAX = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic             frame_valid, sync_err, busy;
    logic [1:0]       slot;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(WIDTH), .GAP_MAX(GAP_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .frame_valid(frame_valid), .sync_err(sync_err), .slot(slot), .busy(busy)
    );

    typedef struct packed {
        logic        is_err;
        logic [31:0] yv;
    } ev_t;

    ev_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_frames = 0;
    int n_errs = 0;

    // Reference model: the frame is just a list of words received so far.
    logic [7:0]  words[4];
    int          cnt = 0;
    int          gap = 0;
    logic [31:0] y_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input logic fs, input logic [7:0] d);
        ev_t e;
        if (!v) begin
            if (cnt != 0) begin
                gap++;
                if (gap == GAP_MAX) begin
                    e.is_err = 1'b1; e.yv = '0; exp_q.push_back(e);
                    cnt = 0; gap = 0;
                end
            end
        end else if (fs) begin
            if (cnt != 0) begin
                e.is_err = 1'b1; e.yv = '0; exp_q.push_back(e);
            end
            words[0] = d; cnt = 1; gap = 0;
        end else if (cnt != 0) begin
            words[cnt] = d; cnt++; gap = 0;
            if (cnt == 4) begin
                y_exp = {words[0], words[1], words[2], words[3]};
                e.is_err = 1'b0; e.yv = y_exp; exp_q.push_back(e);
                cnt = 0;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".slot"}, 32'(slot), 32'(cnt));
        check({tag, ".busy"}, 32'(busy), 32'(cnt != 0));
        check({tag, ".y"}, {y0, y1, y2, y3}, y_exp);
    endtask

    task automatic step(input logic v, input logic fs, input logic [7:0] d);
        din_valid = v; frame_start = fs; din = d;
        model_step(v, fs, d);
        @(posedge clk); #1;
        check_state("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 8'($urandom));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1; frame_start = 1'($urandom); din = 8'($urandom);
            @(posedge clk); #1;
        end
        cnt = 0; gap = 0; y_exp = '0;
        check_state("reset");
        check("reset.pulses", {31'd0, frame_valid | sync_err}, 32'd0);
        rst_n = 1'b1;
        din_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, b, c, e);
        step(1'b1, 1'b1, a); step(1'b1, 1'b0, b);
        step(1'b1, 1'b0, c); step(1'b1, 1'b0, e);
    endtask

    // Monitor: every pulse the DUT presents must match the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if (frame_valid && sync_err) begin
            check("mon.both_pulses", 32'd1, 32'd0);
        end else if (frame_valid || sync_err) begin
            if (exp_q.size() == 0) begin
                check("mon.unexpected_pulse", {30'd0, frame_valid, sync_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("mon.kind_err", 32'(sync_err), 32'(e.is_err));
                if (!e.is_err) check("mon.frame_y", {y0, y1, y2, y3}, e.yv);
                if (e.is_err) n_errs++; else n_frames++;
            end
        end
    end

    initial begin
        int r, f0, e0;
        @(posedge clk); #1;
        do_reset(2);

        // Reset mid-frame after a good frame clears everything.
        frame(8'h5a, 8'h6b, 8'h7c, 8'h8d);
        step(1'b1, 1'b1, 8'h99); step(1'b1, 1'b0, 8'h98);
        do_reset(2);

        // Plain frame.
        f0 = n_frames;
        frame(8'h11, 8'h22, 8'h33, 8'h44);
        step(1'b0, 1'b0, 8'h00); step(1'b0, 1'b0, 8'h00);
        check("t2.one_frame", 32'(n_frames - f0), 32'd1);

        // Same frame with idle gaps between beats.
        f0 = n_frames; e0 = n_errs;
        step(1'b1, 1'b1, 8'h11); idle(2);
        step(1'b1, 1'b0, 8'h22); idle(2);
        step(1'b1, 1'b0, 8'h33); idle(2);
        step(1'b1, 1'b0, 8'h44); idle(2);
        check("t3.frames", 32'(n_frames - f0), 32'd1);
        check("t3.errs", 32'(n_errs - e0), 32'd0);

        // Resync mid-frame.
        e0 = n_errs;
        step(1'b1, 1'b1, 8'ha1); step(1'b1, 1'b0, 8'ha2);
        frame(8'hb1, 8'hb2, 8'hb3, 8'hb4);
        idle(1);
        check("t4.errs", 32'(n_errs - e0), 32'd1);

        // Stall abort after GAP_MAX idle cycles, and one short of it.
        e0 = n_errs;
        step(1'b1, 1'b1, 8'h01); step(1'b1, 1'b0, 8'h02);
        idle(GAP_MAX - 1);
        step(1'b1, 1'b0, 8'h03);
        idle(GAP_MAX);
        idle(1);
        check("t5.errs", 32'(n_errs - e0), 32'd1);

        // Stray beats in IDLE, then back-to-back frames.
        step(1'b1, 1'b0, 8'h55); step(1'b1, 1'b0, 8'h56);
        f0 = n_frames;
        for (int k = 0; k < 6; k++)
            frame(8'(k * 4), 8'(k * 4 + 1), 8'(k * 4 + 2), 8'(k * 4 + 3));
        idle(1);
        check("t6.frames", 32'(n_frames - f0), 32'd6);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_reset(int'($urandom_range(1, 2)));
            end else if (r < 30) begin
                idle(int'($urandom_range(GAP_MAX - 2, GAP_MAX + 2)));
            end else if (r < 750) begin
                if (cnt == 0) step(1'b1, ($urandom_range(0, 9) != 0), 8'($urandom));
                else          step(1'b1, ($urandom_range(0, 19) == 0), 8'($urandom));
            end else begin
                step(1'b0, 1'($urandom), 8'($urandom));
            end
        end
        idle(2);
        check("end.queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
